ctu_tsr_seq_ctl: RTL and testbench

//  Sequencer for the on-die temperature sensor behind the CTU pad cluster tsr_testio pins.

---
 rtl/ctu_tsr_pkg.sv | 23 ++
 rtl/ctu_tsr_sync.sv | 22 ++
 rtl/ctu_tsr_seq_ctl.sv | 206 ++++++++++++++++++++
 tb/tb_ctu_tsr_seq_ctl.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctu_tsr_pkg.sv
// Shared definitions for the CTU temperature-sensor sequencer: state encoding,
// default data widths and a small constant helper.
package ctu_tsr_pkg;

    localparam int CODE_W_DEF   = 8;
    localparam int AVG_LOG2_DEF = 2;

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_SETTLE = 3'd1,
        ST_START  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_ACC    = 3'd4,
        ST_IDLE   = 3'd5
    } tsr_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ctu_tsr_sync.sv
// Two-flop synchronizer with asynchronous active-low reset, used to bring the
// analog macro's conversion-done level into the CTU clock domain.
module ctu_tsr_sync (
    input  logic clk,
    input  logic arst_l,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ctu_tsr_seq_ctl.sv
// Temperature-sensor sequencer: power-up and settle, periodic conversions,
// 2**AVG_LOG2-sample averaging, hysteretic overtemp alarm and sticky timeout error.
module ctu_tsr_seq_ctl
    import ctu_tsr_pkg::*;
#(
    parameter int CODE_W      = CODE_W_DEF,
    parameter int AVG_LOG2    = AVG_LOG2_DEF,
    parameter int SETTLE_CYC  = 256,
    parameter int TIMEOUT_CYC = 1024,
    parameter int PER_W       = 16
) (
    input  logic              clk,
    input  logic              arst_l,
    input  logic              cfg_en,
    input  logic [PER_W-1:0]  cfg_period,
    input  logic [CODE_W-1:0] cfg_hi_thr,
    input  logic [CODE_W-1:0] cfg_lo_thr,
    input  logic              err_clr,
    output logic              tsr_pwr_en,
    output logic              tsr_conv_start,
    input  logic              tsr_conv_done,
    input  logic [CODE_W-1:0] tsr_code,
    output logic [CODE_W-1:0] temp_val,
    output logic              temp_vld,
    output logic              overtemp,
    output logic              tsr_timeout_err
);

    localparam int SUM_W  = CODE_W + AVG_LOG2;
    localparam int NSAMP  = 1 << AVG_LOG2;
    localparam int SCNT_W = AVG_LOG2 + 1;
    localparam int CNT_W  = max3($clog2(SETTLE_CYC), $clog2(TIMEOUT_CYC), PER_W);

    localparam logic [CNT_W-1:0]  SETTLE_LD  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LD = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [SCNT_W-1:0] LAST_SAMP  = SCNT_W'(NSAMP - 1);

    tsr_state_e state, nxt;

    logic              done_s;
    logic              done_q;
    logic              done_rise;
    logic [CNT_W-1:0]  cnt;
    logic [CODE_W-1:0] code_q;
    logic [SUM_W-1:0]  sum;
    logic [SUM_W-1:0]  sum_nxt;
    logic [SCNT_W-1:0] samp_cnt;
    logic [CODE_W-1:0] avg;

    logic              cnt_ld;
    logic [CNT_W-1:0]  cnt_ld_val;
    logic              cnt_dec;
    logic              cap;
    logic              acc_add;
    logic              acc_last;
    logic              acc_clr;
    logic              to_set;

    ctu_tsr_sync u_done_sync (
        .clk    (clk),
        .arst_l (arst_l),
        .d      (tsr_conv_done),
        .q      (done_s)
    );

    assign done_rise = done_s & ~done_q;
    assign sum_nxt   = sum + SUM_W'(code_q);
    assign avg       = sum_nxt[SUM_W-1:AVG_LOG2];

    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            state <= ST_OFF;
        end else begin
            state <= nxt;
        end
    end

    // One down-counter serves settle, conversion timeout and idle period; each
    // state loads it on entry and leaves when it reads zero.
    always_comb begin
        nxt        = state;
        cnt_ld     = 1'b0;
        cnt_ld_val = '0;
        cnt_dec    = 1'b0;
        cap        = 1'b0;
        acc_add    = 1'b0;
        acc_last   = 1'b0;
        acc_clr    = 1'b0;
        to_set     = 1'b0;

        if (!cfg_en) begin
            nxt     = ST_OFF;
            acc_clr = 1'b1;
        end else begin
            case (state)
                ST_OFF: begin
                    nxt        = ST_SETTLE;
                    cnt_ld     = 1'b1;
                    cnt_ld_val = SETTLE_LD;
                    acc_clr    = 1'b1;
                end
                ST_SETTLE: begin
                    if (cnt == '0) begin
                        nxt = ST_START;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                ST_START: begin
                    nxt        = ST_WAIT;
                    cnt_ld     = 1'b1;
                    cnt_ld_val = TIMEOUT_LD;
                end
                ST_WAIT: begin
                    if (done_rise) begin
                        cap = 1'b1;
                        nxt = ST_ACC;
                    end else if (cnt == '0) begin
                        to_set     = 1'b1;
                        acc_clr    = 1'b1;
                        nxt        = ST_IDLE;
                        cnt_ld     = 1'b1;
                        cnt_ld_val = CNT_W'(cfg_period);
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                ST_ACC: begin
                    acc_add = 1'b1;
                    if (samp_cnt == LAST_SAMP) begin
                        acc_last   = 1'b1;
                        nxt        = ST_IDLE;
                        cnt_ld     = 1'b1;
                        cnt_ld_val = CNT_W'(cfg_period);
                    end else begin
                        nxt = ST_START;
                    end
                end
                ST_IDLE: begin
                    if (cnt == '0) begin
                        nxt = ST_START;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                default: begin
                    nxt = ST_OFF;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            done_q          <= 1'b0;
            cnt             <= '0;
            code_q          <= '0;
            sum             <= '0;
            samp_cnt        <= '0;
            temp_val        <= '0;
            temp_vld        <= 1'b0;
            overtemp        <= 1'b0;
            tsr_timeout_err <= 1'b0;
            tsr_pwr_en      <= 1'b0;
            tsr_conv_start  <= 1'b0;
        end else begin
            done_q <= done_s;

            if (cnt_ld) begin
                cnt <= cnt_ld_val;
            end else if (cnt_dec) begin
                cnt <= cnt - CNT_W'(1);
            end

            if (cap) begin
                code_q <= tsr_code;
            end

            if (acc_clr || acc_last) begin
                sum      <= '0;
                samp_cnt <= '0;
            end else if (acc_add) begin
                sum      <= sum_nxt;
                samp_cnt <= samp_cnt + SCNT_W'(1);
            end

            temp_vld <= acc_last;
            if (acc_last) begin
                temp_val <= avg;
                // Set takes priority so overlapping thresholds still raise the alarm.
                if (avg >= cfg_hi_thr) begin
                    overtemp <= 1'b1;
                end else if (avg <= cfg_lo_thr) begin
                    overtemp <= 1'b0;
                end
            end

            tsr_timeout_err <= to_set | (tsr_timeout_err & ~err_clr);

            // Pad controls are registered from the next state to stay glitch-free.
            tsr_pwr_en     <= (nxt != ST_OFF);
            tsr_conv_start <= (nxt == ST_START);
        end
    end

endmodule

// File: tb/tb_ctu_tsr_seq_ctl.sv
// Self-checking bench for ctu_tsr_seq_ctl: analog macro model, transaction-level
// averaging/alarm model with per-cycle compare, and directed literal scenarios.
module tb_ctu_tsr_seq_ctl;

    logic        clk = 1'b0;
    logic        arst_l;
    logic        cfg_en;
    logic [15:0] cfg_period;
    logic [7:0]  cfg_hi_thr;
    logic [7:0]  cfg_lo_thr;
    logic        err_clr;
    logic        tsr_pwr_en;
    logic        tsr_conv_start;
    logic        tsr_conv_done;
    logic [7:0]  tsr_code;
    logic [7:0]  temp_val;
    logic        temp_vld;
    logic        overtemp;
    logic        tsr_timeout_err;

    always #5 clk = ~clk;

    ctu_tsr_seq_ctl #(
        .CODE_W      (8),
        .AVG_LOG2    (2),
        .SETTLE_CYC  (256),
        .TIMEOUT_CYC (1024),
        .PER_W       (16)
    ) dut (
        .clk             (clk),
        .arst_l          (arst_l),
        .cfg_en          (cfg_en),
        .cfg_period      (cfg_period),
        .cfg_hi_thr      (cfg_hi_thr),
        .cfg_lo_thr      (cfg_lo_thr),
        .err_clr         (err_clr),
        .tsr_pwr_en      (tsr_pwr_en),
        .tsr_conv_start  (tsr_conv_start),
        .tsr_conv_done   (tsr_conv_done),
        .tsr_code        (tsr_code),
        .temp_val        (temp_val),
        .temp_vld        (temp_vld),
        .overtemp        (overtemp),
        .tsr_timeout_err (tsr_timeout_err)
    );

    typedef struct {
        int val;
        int dl;
    } exp_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    exp_t       exp_q[$];
    int         samp[$];
    logic [7:0] code_q[$];
    int         m_temp = 0;
    int         m_ot = 0;
    int         start_cnt = 0;
    int         deliv_cnt = 0;
    bit         resp_en = 1'b1;
    int         conv_lat = 3;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_abort();
        samp.delete();
        code_q.delete();
        start_cnt = 0;
    endtask

    task automatic model_reset();
        model_abort();
        exp_q.delete();
        m_temp = 0;
        m_ot = 0;
    endtask

    // Analog macro: answers each start after conv_lat cycles with the next queued code.
    initial begin
        logic [7:0] c;
        int         s;
        exp_t       e;
        tsr_conv_done = 1'b0;
        tsr_code = '0;
        forever begin
            @(negedge clk);
            if (tsr_conv_start && resp_en && cfg_en && arst_l) begin
                repeat (conv_lat) @(negedge clk);
                c = (code_q.size() > 0) ? code_q.pop_front() : 8'h40;
                tsr_code = c;
                tsr_conv_done = 1'b1;
                if (cfg_en && arst_l) begin
                    deliv_cnt++;
                    samp.push_back(int'(c));
                    if (samp.size() == 4) begin
                        s = 0;
                        foreach (samp[i]) s += samp[i];
                        e.val = s / 4;
                        e.dl = cyc + 8;
                        exp_q.push_back(e);
                        samp.delete();
                    end
                end
                repeat (3) @(negedge clk);
                tsr_conv_done = 1'b0;
                tsr_code = '0;
            end
        end
    end

    // Per-cycle compare against the transaction-level model.
    initial begin
        bit   prev_start;
        bit   en_prev;
        exp_t e;
        prev_start = 1'b0;
        en_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!arst_l) begin
                prev_start = 1'b0;
                en_prev = cfg_en;
            end else begin
                if (exp_q.size() > 0 && cyc > exp_q[0].dl) begin
                    checks++;
                    errors++;
                    $display("FAIL vld_deadline: no temp_vld by cycle %0d, expected value %0d", cyc, exp_q[0].val);
                    void'(exp_q.pop_front());
                end
                if (temp_vld) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_vld: temp_vld=1 value %0d, expected no update", temp_val);
                    end else begin
                        e = exp_q.pop_front();
                        m_temp = e.val;
                        if (e.val >= int'(cfg_hi_thr)) m_ot = 1;
                        else if (e.val <= int'(cfg_lo_thr)) m_ot = 0;
                        chk("model_temp_val", temp_val, m_temp);
                        chk("model_overtemp", overtemp, m_ot);
                        chk("starts_per_meas", start_cnt, 4);
                    end
                    start_cnt = 0;
                end else begin
                    chk("temp_val_hold", temp_val, m_temp);
                    chk("overtemp_hold", overtemp, m_ot);
                end
                if (tsr_conv_start) begin
                    start_cnt++;
                    chk("start_one_cycle", prev_start, 0);
                    chk("start_after_dis", en_prev, 1);
                    chk("start_needs_pwr", tsr_pwr_en, 1);
                end
                if (!en_prev) chk("pwr_off_after_dis", tsr_pwr_en, 0);
                prev_start = tsr_conv_start;
                en_prev = cfg_en;
            end
        end
    end

    task automatic wait_vld(input string nm, input int maxc);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (temp_vld) begin
                ok = 1'b1;
                break;
            end
        end
        chk(nm, ok, 1);
    endtask

    task automatic wait_start(input int maxc, output int n);
        n = -1;
        for (int i = 1; i <= maxc; i++) begin
            @(negedge clk);
            if (tsr_conv_start) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic check_settle(input string nm);
        int n;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (tsr_pwr_en) break;
        end
        chk({nm, "_pwr_up"}, tsr_pwr_en, 1);
        wait_start(400, n);
        chk({nm, "_settle_cycles"}, n, 256);
    endtask

    // Called at a measurement boundary; gap_exp<0 skips the idle-gap check.
    task automatic meas(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                        input logic [7:0] c3, input int exp_avg, input int exp_ot, input int gap_exp);
        int n;
        code_q.push_back(c0);
        code_q.push_back(c1);
        code_q.push_back(c2);
        code_q.push_back(c3);
        wait_vld("meas_vld_seen", 600);
        chk("meas_avg", temp_val, exp_avg);
        chk("meas_overtemp", overtemp, exp_ot);
        if (gap_exp >= 0) begin
            n = -1;
            for (int i = 1; i <= 60; i++) begin
                @(negedge clk);
                if (i == 1) chk("vld_one_cycle", temp_vld, 0);
                if (tsr_conv_start) begin
                    n = i;
                    break;
                end
            end
            chk("idle_gap", n, gap_exp);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int d0;
        arst_l = 1'b0;
        cfg_en = 1'b0;
        cfg_period = 16'd10;
        cfg_hi_thr = 8'd200;
        cfg_lo_thr = 8'd150;
        err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pwr_en", tsr_pwr_en, 0);
        chk("rst_conv_start", tsr_conv_start, 0);
        chk("rst_temp_val", temp_val, 0);
        chk("rst_temp_vld", temp_vld, 0);
        chk("rst_overtemp", overtemp, 0);
        chk("rst_timeout_err", tsr_timeout_err, 0);
        arst_l = 1'b1;
        @(posedge clk);
        #1;

        // Basic averaging with truncation, period 10.
        conv_lat = 3;
        code_q.push_back(8'd100);
        code_q.push_back(8'd101);
        code_q.push_back(8'd102);
        code_q.push_back(8'd103);
        cfg_en = 1'b1;
        check_settle("t2");
        wait_vld("t2_vld_seen", 300);
        chk("t2_avg", temp_val, 101);
        chk("t2_overtemp", overtemp, 0);
        @(negedge clk);
        chk("t2_vld_one_cycle", temp_vld, 0);
        wait_start(40, n);
        chk("t2_idle_gap", n, 10);
        wait_vld("t2_boundary", 300);
        @(posedge clk);
        #1;

        // Hysteresis.
        conv_lat = 6;
        cfg_hi_thr = 8'd120;
        cfg_lo_thr = 8'd110;
        meas(8'd124, 8'd125, 8'd126, 8'd127, 125, 1, 11);
        meas(8'd115, 8'd115, 8'd116, 8'd116, 115, 1, -1);
        meas(8'd104, 8'd105, 8'd106, 8'd107, 105, 0, -1);
        meas(8'd120, 8'd120, 8'd121, 8'd121, 120, 1, -1);
        meas(8'd110, 8'd110, 8'd110, 8'd111, 110, 0, -1);
        cfg_hi_thr = 8'd100;
        cfg_lo_thr = 8'd130;
        meas(8'd114, 8'd115, 8'd116, 8'd117, 115, 1, -1);

        // Disable after two samples, then re-enable.
        conv_lat = 4;
        cfg_hi_thr = 8'd250;
        cfg_lo_thr = 8'd150;
        code_q.push_back(8'd10);
        code_q.push_back(8'd20);
        code_q.push_back(8'd30);
        d0 = deliv_cnt;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (deliv_cnt >= d0 + 2) break;
        end
        chk("t5_two_samples", deliv_cnt - d0, 2);
        wait_start(40, n);
        chk("t5_third_start", n > 0, 1);
        @(posedge clk);
        #1;
        cfg_en = 1'b0;
        model_abort();
        @(posedge clk);
        @(negedge clk);
        chk("t5_pwr_off", tsr_pwr_en, 0);
        chk("t5_temp_kept", temp_val, 115);
        chk("t5_overtemp_kept", overtemp, 1);
        repeat (20) @(posedge clk);
        #1;
        code_q.push_back(8'd200);
        code_q.push_back(8'd201);
        code_q.push_back(8'd202);
        code_q.push_back(8'd203);
        cfg_en = 1'b1;
        check_settle("t5");
        wait_vld("t5_vld_seen", 300);
        chk("t5_fresh_avg", temp_val, 201);
        chk("t5_overtemp", overtemp, 1);
        @(posedge clk);
        #1;

        // Back-to-back with full-scale codes.
        cfg_period = 16'd0;
        cfg_hi_thr = 8'hF0;
        cfg_lo_thr = 8'h10;
        meas(8'hFF, 8'hFF, 8'hFF, 8'hFF, 255, 1, -1);
        meas(8'hFF, 8'hFF, 8'hFF, 8'hFF, 255, 1, 1);

        // Conversion timeout and error clearing.
        cfg_period = 16'd10;
        wait_vld("t4_boundary", 300);
        @(posedge clk);
        #1;
        resp_en = 1'b0;
        wait_start(40, n);
        chk("t4_start_seen", n > 0, 1);
        n = -1;
        for (int i = 1; i <= 1100; i++) begin
            @(negedge clk);
            if (tsr_timeout_err) begin
                n = i;
                break;
            end
        end
        chk("t4_timeout_cycles", n, 1025);
        @(posedge clk);
        #1;
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        @(negedge clk);
        chk("t4_err_cleared", tsr_timeout_err, 0);
        wait_start(40, n);
        chk("t4_restart_seen", n > 0, 1);
        repeat (1024) @(posedge clk);
        #1;
        err_clr = 1'b1;
        @(negedge clk);
        chk("t4_err_before_timeout", tsr_timeout_err, 0);
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        @(negedge clk);
        chk("t4_set_beats_clr", tsr_timeout_err, 1);
        chk("t4_temp_unchanged", temp_val, 64);

        // Asynchronous reset in the middle of a conversion wait.
        wait_start(40, n);
        chk("t1_start_seen", n > 0, 1);
        repeat (5) @(posedge clk);
        #3;
        arst_l = 1'b0;
        model_reset();
        #1;
        chk("t1_pwr_en", tsr_pwr_en, 0);
        chk("t1_conv_start", tsr_conv_start, 0);
        chk("t1_temp_val", temp_val, 0);
        chk("t1_temp_vld", temp_vld, 0);
        chk("t1_overtemp", overtemp, 0);
        chk("t1_timeout_err", tsr_timeout_err, 0);
        cfg_en = 1'b0;
        @(posedge clk);
        #1;
        arst_l = 1'b1;
        repeat (3) @(negedge clk);
        chk("t1_stays_off", tsr_pwr_en, 0);
        chk("t1_no_start", tsr_conv_start, 0);

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
